// File: rtl/scaler_vlinegen_pkg.sv
// Shared definitions for the vertical line/phase generator.
// Holds the FSM state encoding and the fixed-point widths used by
// scaler_vlinegen and its bus interface.
package scaler_vlinegen_pkg;

  // Fixed-point layout of step/accumulator: Q(LINE_W+1).FRAC_W.
  localparam int VL_FRAC_W   = 17;
  localparam int VL_PHASE_W  = 8;
  localparam int VL_LINE_W   = 10;
  localparam int VL_CNT_W    = 11;
  localparam int VL_FACTOR_W = 18;
  // One guard bit above the integer field so overflow past the last
  // addressable line is still visible before the clamp.
  localparam int VL_ACC_W    = VL_FRAC_W + VL_LINE_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP0 = 3'd1,
    ST_SETUP1 = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DONE   = 3'd4
  } vl_state_t;

endpackage

// File: rtl/scaler_vlinegen_if.sv
// Bus between the scaler output timing / config generator (master) and
// the vertical line generator (slave).
//   frame_start_i      : frame restart pulse, latches config
//   line_req_i         : one pulse per output line
//   vpos_1st_rdline_i  : first input line to read
//   vlines_in_needed_i : input lines spanned by the scaled image
//   vlines_out_i       : output active lines
//   v_interp_factor_i  : floor(2^17 / vlines_out)
//   rdy_o              : generator accepts requests
//   line_valid_o       : one-cycle result strobe
//   line_a_o/line_b_o  : source lines to blend
//   phase_o            : weight of line_b
//   out_line_cnt_o     : requests accepted this frame
//   frame_done_o       : all output lines of the frame issued
interface scaler_vlinegen_if;
  import scaler_vlinegen_pkg::*;

  logic                   frame_start_i;
  logic                   line_req_i;
  logic [VL_LINE_W-1:0]   vpos_1st_rdline_i;
  logic [VL_LINE_W-1:0]   vlines_in_needed_i;
  logic [VL_CNT_W-1:0]    vlines_out_i;
  logic [VL_FACTOR_W-1:0] v_interp_factor_i;

  logic                   rdy_o;
  logic                   line_valid_o;
  logic [VL_LINE_W-1:0]   line_a_o;
  logic [VL_LINE_W-1:0]   line_b_o;
  logic [VL_PHASE_W-1:0]  phase_o;
  logic [VL_CNT_W-1:0]    out_line_cnt_o;
  logic                   frame_done_o;

  modport master (
    output frame_start_i, line_req_i, vpos_1st_rdline_i,
           vlines_in_needed_i, vlines_out_i, v_interp_factor_i,
    input  rdy_o, line_valid_o, line_a_o, line_b_o, phase_o,
           out_line_cnt_o, frame_done_o
  );

  modport slave (
    input  frame_start_i, line_req_i, vpos_1st_rdline_i,
           vlines_in_needed_i, vlines_out_i, v_interp_factor_i,
    output rdy_o, line_valid_o, line_a_o, line_b_o, phase_o,
           out_line_cnt_o, frame_done_o
  );
endinterface

// File: rtl/scaler_vlinegen.sv
// Per-frame vertical source-line and phase generator.
// For every accepted output-line request it returns the two buffered
// input lines to blend and an 8-bit blend phase, two cycles later.
// Ports:
//   SYS_CLK : system clock
//   SYS_RST : asynchronous active-high reset
//   bus     : scaler_vlinegen_if.slave (requests, config, results)
module scaler_vlinegen
  import scaler_vlinegen_pkg::*;
#(
  parameter int FRAC_W  = VL_FRAC_W,
  parameter int PHASE_W = VL_PHASE_W
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  scaler_vlinegen_if.slave bus
);

  localparam int ACC_W = FRAC_W + VL_LINE_W + 1;
  // Half an output-line step minus half an input line centres the
  // sampling grid of the output lines over the input lines.
  localparam logic [ACC_W-1:0] CENTER = ACC_W'(1) << (FRAC_W - 1);

  vl_state_t state_reg, state_next;

  logic [VL_LINE_W-1:0]   vpos_reg;
  logic [VL_LINE_W-1:0]   needed_reg;
  logic [VL_CNT_W-1:0]    vout_reg;
  logic [VL_FACTOR_W-1:0] factor_reg;

  logic [ACC_W-1:0]       step_reg;
  logic [ACC_W-1:0]       acc_reg;
  logic [VL_CNT_W-1:0]    cnt_reg;

  logic                   s1_valid_reg;
  logic [ACC_W-1:0]       s1_acc_reg;
  logic                   s2_valid_reg;
  logic [VL_LINE_W-1:0]   s2_int_reg;
  logic [VL_LINE_W-1:0]   s2_b_reg;
  logic [PHASE_W-1:0]     s2_frac_reg;

  logic                   out_valid_reg;
  logic [VL_LINE_W-1:0]   out_a_reg;
  logic [VL_LINE_W-1:0]   out_b_reg;
  logic [PHASE_W-1:0]     out_phase_reg;

  logic                   accept;
  logic [VL_CNT_W-1:0]    cnt_inc;
  (* multstyle = "dsp" *)
  logic [ACC_W-1:0]       product;
  logic [ACC_W-1:0]       step_half;
  logic [ACC_W-1:0]       acc_init;
  logic [ACC_W:0]         acc_sum;
  logic [ACC_W-1:0]       acc_inc;
  logic [VL_LINE_W-1:0]   last_line;
  logic [VL_LINE_W-1:0]   raw_int;
  logic                   over;
  logic [VL_LINE_W-1:0]   int_c;
  logic [VL_LINE_W-1:0]   b_c;
  logic [PHASE_W-1:0]     frac_c;

  // frame_start has priority: a coincident request is dropped.
  assign accept  = (state_reg == ST_ACTIVE) && bus.line_req_i && !bus.frame_start_i;
  assign cnt_inc = cnt_reg + VL_CNT_W'(1);

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.frame_start_i) begin
      state_next = ST_SETUP0;
    end else begin
      unique case (state_reg)
        ST_IDLE:   state_next = ST_IDLE;
        ST_SETUP0: state_next = ST_SETUP1;
        ST_SETUP1: state_next = (vout_reg == '0) ? ST_DONE : ST_ACTIVE;
        ST_ACTIVE: begin
          // Compare against the incremented count so DONE coincides
          // with the edge that accepts the final request.
          if (accept && (cnt_inc == vout_reg)) state_next = ST_DONE;
        end
        ST_DONE:   state_next = ST_DONE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------
  always_comb begin
    product   = ACC_W'(needed_reg) * ACC_W'(factor_reg);
    step_half = step_reg >> 1;
    acc_init  = (step_half >= CENTER) ? (step_half - CENTER) : '0;
    acc_sum   = {1'b0, acc_reg} + {1'b0, step_reg};
    acc_inc   = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  end

  // Stage-2 combinational: split, clamp to the last input line and
  // derive the lower line. When both lines coincide the blend weight is
  // meaningless, so it is forced to zero.
  always_comb begin
    last_line = needed_reg - VL_LINE_W'(1);
    raw_int   = s1_acc_reg[FRAC_W +: VL_LINE_W];
    over      = s1_acc_reg[ACC_W-1] || (raw_int > last_line);
    int_c     = over ? last_line : raw_int;
    b_c       = (int_c < last_line) ? (int_c + VL_LINE_W'(1)) : last_line;
    frac_c    = (over || (b_c == int_c)) ? '0 : s1_acc_reg[FRAC_W-PHASE_W +: PHASE_W];
  end

  // ---------------------------------------------------------------
  // Config, accumulator and result pipeline
  // ---------------------------------------------------------------
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      vpos_reg      <= '0;
      needed_reg    <= '0;
      vout_reg      <= '0;
      factor_reg    <= '0;
      step_reg      <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      s1_valid_reg  <= 1'b0;
      s1_acc_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_int_reg    <= '0;
      s2_b_reg      <= '0;
      s2_frac_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_phase_reg <= '0;
    end else if (bus.frame_start_i) begin
      vpos_reg      <= bus.vpos_1st_rdline_i;
      needed_reg    <= bus.vlines_in_needed_i;
      vout_reg      <= bus.vlines_out_i;
      factor_reg    <= bus.v_interp_factor_i;
      cnt_reg       <= '0;
      // Flush in-flight results of the previous frame.
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (state_reg == ST_SETUP0) step_reg <= product;
      if (state_reg == ST_SETUP1) acc_reg  <= acc_init;

      s1_valid_reg <= accept;
      if (accept) begin
        s1_acc_reg <= acc_reg;
        acc_reg    <= acc_inc;
        cnt_reg    <= cnt_inc;
      end

      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_int_reg  <= int_c;
        s2_b_reg    <= b_c;
        s2_frac_reg <= frac_c;
      end

      // Result registers hold between strobes.
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_a_reg     <= vpos_reg + s2_int_reg;
        out_b_reg     <= vpos_reg + s2_b_reg;
        out_phase_reg <= s2_frac_reg;
      end
    end
  end

  assign bus.rdy_o          = (state_reg == ST_ACTIVE);
  assign bus.frame_done_o   = (state_reg == ST_DONE);
  assign bus.line_valid_o   = out_valid_reg;
  assign bus.line_a_o       = out_a_reg;
  assign bus.line_b_o       = out_b_reg;
  assign bus.phase_o        = out_phase_reg;
  assign bus.out_line_cnt_o = cnt_reg;

endmodule

// File: tb/tb_scaler_vlinegen.sv
module tb_scaler_vlinegen;

  logic clk;
  logic rst;

  scaler_vlinegen_if bus ();

  scaler_vlinegen dut (
    .SYS_CLK (clk),
    .SYS_RST (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int a_q[$];
  int b_q[$];
  int p_q[$];
  int first_valid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int vpos, input int needed, input int vout, input int factor);
    bus.vpos_1st_rdline_i  = 10'(vpos);
    bus.vlines_in_needed_i = 10'(needed);
    bus.vlines_out_i       = 11'(vout);
    bus.v_interp_factor_i  = 18'(factor);
  endtask

  task automatic start_frame(input int vpos, input int needed, input int vout, input int factor);
    set_cfg(vpos, needed, vout, factor);
    bus.frame_start_i = 1'b1;
    tick();
    bus.frame_start_i = 1'b0;
    tick();
    tick();
  endtask

  // Drive n back-to-back requests, then two idle cycles; log every strobe.
  task automatic burst(input int n);
    a_q.delete();
    b_q.delete();
    p_q.delete();
    first_valid = -1;
    for (int t = 0; t < n + 2; t++) begin
      bus.line_req_i = (t < n);
      tick();
      if (bus.line_valid_o) begin
        if (first_valid < 0) first_valid = t;
        a_q.push_back(int'(bus.line_a_o));
        b_q.push_back(int'(bus.line_b_o));
        p_q.push_back(int'(bus.phase_o));
      end
    end
    bus.line_req_i = 1'b0;
  endtask

  task automatic check_line(input string tag, input int idx, input int ea, input int eb, input int ep);
    if (idx < a_q.size()) begin
      check_val({tag, "_a"}, a_q[idx], ea);
      check_val({tag, "_b"}, b_q[idx], eb);
      check_val({tag, "_ph"}, p_q[idx], ep);
    end else begin
      check_val({tag, "_present"}, a_q.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[6];
    int exp_b[6];
    int exp_p[6];
    int nval;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.frame_start_i = 1'b0;
    bus.line_req_i    = 1'b0;
    set_cfg(0, 0, 0, 0);

    // Reset state
    #12;
    check_val("rst_valid", bus.line_valid_o, 0);
    check_val("rst_rdy", bus.rdy_o, 0);
    check_val("rst_done", bus.frame_done_o, 0);
    check_val("rst_cnt", bus.out_line_cnt_o, 0);
    check_val("rst_a", bus.line_a_o, 0);
    #11 rst = 1'b0;
    tick();

    // Request in IDLE is dropped
    burst(1);
    check_val("idle_req_valids", a_q.size(), 0);
    check_val("idle_req_cnt", bus.out_line_cnt_o, 0);

    // Upscale: step 32640, acc0 0
    start_frame(0, 240, 960, 136);
    check_val("up_rdy", bus.rdy_o, 1);
    burst(6);
    check_val("up_latency", first_valid, 2);
    check_val("up_nvalid", a_q.size(), 6);
    exp_a = '{0, 0, 0, 0, 0, 1};
    exp_b = '{1, 1, 1, 1, 1, 2};
    exp_p = '{0, 63, 127, 191, 255, 62};
    for (int i = 0; i < 6; i++) begin
      check_line($sformatf("up_req%0d", i), i, exp_a[i], exp_b[i], exp_p[i]);
    end
    check_val("up_cnt", bus.out_line_cnt_o, 6);
    tick();
    check_val("up_valid_drop", bus.line_valid_o, 0);
    check_val("up_hold_a", bus.line_a_o, 1);

    // Downscale: step 262020, acc0 65474; mid-frame config change ignored
    start_frame(10, 220, 110, 1191);
    burst(1);
    check_line("down_req0", 0, 10, 11, 127);
    set_cfg(100, 5, 5, 26214);
    burst(1);
    check_line("down_req1", 0, 12, 13, 127);

    // frame_start coincident with a request, with a request in flight
    bus.line_req_i = 1'b1;
    tick();
    bus.frame_start_i = 1'b1;
    tick();
    bus.frame_start_i = 1'b0;
    bus.line_req_i    = 1'b0;
    check_val("fs_req_cnt", bus.out_line_cnt_o, 0);
    check_val("fs_req_valid1", bus.line_valid_o, 0);
    check_val("fs_req_rdy1", bus.rdy_o, 0);
    tick();
    check_val("fs_req_valid2", bus.line_valid_o, 0);
    check_val("fs_req_rdy2", bus.rdy_o, 0);
    tick();
    check_val("fs_req_valid3", bus.line_valid_o, 0);
    check_val("fs_req_rdy3", bus.rdy_o, 1);
    // New config now in force: step 131070 -> acc0 0
    burst(1);
    check_line("newcfg_req0", 0, 100, 101, 0);

    // Unity with end clamp: step 131040
    start_frame(0, 240, 240, 546);
    burst(240);
    check_val("unity_nvalid", a_q.size(), 240);
    check_line("unity_req239", 239, 238, 239, 241);
    check_val("unity_done", bus.frame_done_o, 1);
    check_val("unity_rdy", bus.rdy_o, 0);
    check_val("unity_cnt", bus.out_line_cnt_o, 240);
    burst(1);
    check_val("unity_extra_valid", a_q.size(), 0);
    check_val("unity_extra_cnt", bus.out_line_cnt_o, 240);

    // Clamp to last line: step 2^18, acc0 65536
    start_frame(0, 4, 4, 65536);
    burst(3);
    check_line("clamp_req0", 0, 0, 1, 128);
    check_line("clamp_req1", 1, 2, 3, 128);
    check_line("clamp_req2", 2, 3, 3, 0);

    // Accumulator saturation: step 268172289, second acc saturates
    start_frame(0, 1023, 3, 262143);
    burst(2);
    check_line("sat_req0", 0, 1022, 1022, 0);
    check_line("sat_req1", 1, 1022, 1022, 0);

    // vlines_out = 0 goes straight to DONE
    start_frame(0, 10, 0, 100);
    check_val("zero_done", bus.frame_done_o, 1);
    check_val("zero_rdy", bus.rdy_o, 0);

    // Async reset with requests in flight
    start_frame(5, 240, 960, 136);
    bus.line_req_i = 1'b1;
    tick();
    tick();
    tick();
    check_val("arst_pre_valid", bus.line_valid_o, 1);
    check_val("arst_pre_a", bus.line_a_o, 5);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", bus.line_valid_o, 0);
    check_val("arst_a", bus.line_a_o, 0);
    check_val("arst_b", bus.line_b_o, 0);
    check_val("arst_cnt", bus.out_line_cnt_o, 0);
    check_val("arst_rdy", bus.rdy_o, 0);
    #3 rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.line_valid_o) nval++;
    end
    bus.line_req_i = 1'b0;
    check_val("arst_post_valids", nval, 0);
    check_val("arst_post_cnt", bus.out_line_cnt_o, 0);
    start_frame(5, 240, 960, 136);
    burst(1);
    check_line("arst_restart", 0, 5, 6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
